// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: holds the PC, performs one imem read per instruction and presents it until control_unit retires it.
// A zero-wait read gives instr_valid the next cycle (2 cycles/instr minimum); a stalled imem is waited on up to TIMEOUT cycles.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_cur,
  input  logic        pc_write,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        fetch_err,
  output logic [1:0]  err_code,
  output logic [31:0] retired
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_VALID = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]    state_q,    state_d;
  logic [31:0]   pc_q,       pc_d;
  logic [31:0]   pc_cur_q,   pc_cur_d;
  logic [31:0]   instr_q,    instr_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [31:0]   retired_q,  retired_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_cur_d   = pc_cur_q;
    instr_d    = instr_q;
    err_code_d = err_code_q;
    retired_d  = retired_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      S_REQ: begin
        if (imem_ready) begin
          instr_d    = imem_rdata;
          pc_cur_d   = pc_q;
          pc_d       = pc_q + 32'd4;
          wait_cnt_d = '0;
          state_d    = S_VALID;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_code_d = 2'b01;
          state_d    = S_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_VALID: begin
        if (pc_write) begin
          // A misaligned redirect faults without retiring, so pc still points past the offender.
          if (pc_src && (pc_target[1:0] != 2'b00)) begin
            err_code_d = 2'b10;
            state_d    = S_ERR;
          end else begin
            if (pc_src) begin
              pc_d = pc_target;
            end
            retired_d = retired_q + 32'd1;
            state_d   = S_REQ;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pc_cur_q   <= RESET_PC;
      instr_q    <= NOP;
      err_code_q <= 2'b00;
      retired_q  <= 32'd0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_cur_q   <= pc_cur_d;
      instr_q    <= instr_d;
      err_code_q <= err_code_d;
      retired_q  <= retired_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign instr_valid = (state_q == S_VALID);
  assign fetch_err   = (state_q == S_ERR);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_cur      = pc_cur_q;
  assign instruction = instr_q;
  assign err_code    = err_code_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector table plus hand sequences for timeout, reset-while-waiting and PC wrap.
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_cur;
  logic        pc_write;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        fetch_err;
  logic [1:0]  err_code;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_cur      (pc_cur),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .fetch_err   (fetch_err),
    .err_code    (err_code),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        pw;
    logic        src;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc_cur;
    logic        e_err;
    logic [1:0]  e_code;
    logic [31:0] e_ret;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic [31:0] rd,
                       input logic pw, input logic src, input logic [31:0] tgt);
    reset      = r;
    imem_ready = rdy;
    imem_rdata = rd;
    pc_write   = pw;
    pc_src     = src;
    pc_target  = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
  endtask

  initial begin
    //          rst  rdy  rdata          pw   src  tgt            req  addr           vld  instr          pc_cur         err  code   ret
    vecs[0]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,         1'b1,32'h0,        1'b0,32'h0000_0013,32'h0,        1'b0,2'b00,32'd0};
    vecs[1]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,         1'b1,32'h0,        1'b0,32'h0000_0013,32'h0,        1'b0,2'b00,32'd0};
    vecs[2]  = '{1'b0,1'b1,32'h015a04b3, 1'b0,1'b0,32'h0,         1'b0,32'h4,        1'b1,32'h015a04b3,32'h0,        1'b0,2'b00,32'd0};
    vecs[3]  = '{1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,         1'b1,32'h4,        1'b0,32'h015a04b3,32'h0,        1'b0,2'b00,32'd1};
    vecs[4]  = '{1'b0,1'b1,32'h00100093, 1'b0,1'b0,32'h0,         1'b0,32'h8,        1'b1,32'h00100093,32'h4,        1'b0,2'b00,32'd1};
    vecs[5]  = '{1'b0,1'b1,32'hffffffff, 1'b0,1'b0,32'h0,         1'b0,32'h8,        1'b1,32'h00100093,32'h4,        1'b0,2'b00,32'd1};
    vecs[6]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h100,       1'b1,32'h100,      1'b0,32'h00100093,32'h4,        1'b0,2'b00,32'd2};
    vecs[7]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h200,       1'b1,32'h100,      1'b0,32'h00100093,32'h4,        1'b0,2'b00,32'd2};
    vecs[8]  = '{1'b0,1'b1,32'h00000463, 1'b0,1'b0,32'h0,         1'b0,32'h104,      1'b1,32'h00000463,32'h100,      1'b0,2'b00,32'd2};
    vecs[9]  = '{1'b0,1'b0,32'h0,        1'b1,1'b1,32'h102,       1'b0,32'h104,      1'b0,32'h00000463,32'h100,      1'b1,2'b10,32'd2};
    vecs[10] = '{1'b0,1'b1,32'h12345678, 1'b1,1'b0,32'h0,         1'b0,32'h104,      1'b0,32'h00000463,32'h100,      1'b1,2'b10,32'd2};
    vecs[11] = '{1'b1,1'b0,32'h0,        1'b1,1'b1,32'h300,       1'b1,32'h0,        1'b0,32'h0000_0013,32'h0,        1'b0,2'b00,32'd0};

    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rdata, vecs[i].pw, vecs[i].src, vecs[i].tgt);
      step();
      chk($sformatf("v%0d imem_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d imem_addr", i),   imem_addr,            vecs[i].e_addr);
      chk($sformatf("v%0d pc", i),          pc,                   vecs[i].e_addr);
      chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d instruction", i), instruction,          vecs[i].e_instr);
      chk($sformatf("v%0d pc_cur", i),      pc_cur,               vecs[i].e_pc_cur);
      chk($sformatf("v%0d fetch_err", i),   {31'b0, fetch_err},   {31'b0, vecs[i].e_err});
      chk($sformatf("v%0d err_code", i),    {30'b0, err_code},    {30'b0, vecs[i].e_code});
      chk($sformatf("v%0d retired", i),     retired,              vecs[i].e_ret);
    end

    // Timeout: TIMEOUT-1 stalled cycles are tolerated, the TIMEOUT-th faults.
    do_reset();
    for (int c = 0; c < TIMEOUT - 1; c++) idle_step();
    chk("tmo_before_err", {31'b0, fetch_err}, 32'd0);
    chk("tmo_before_req", {31'b0, imem_req},  32'd1);
    idle_step();
    chk("tmo_err",      {31'b0, fetch_err}, 32'd1);
    chk("tmo_code",     {30'b0, err_code},  32'd1);
    chk("tmo_req_low",  {31'b0, imem_req},  32'd0);
    chk("tmo_addr",     imem_addr,          32'h0);

    // Ready at cycle TIMEOUT-2 succeeds, and the wait count restarts for the next fetch.
    do_reset();
    for (int c = 0; c < TIMEOUT - 2; c++) idle_step();
    drive(1'b0, 1'b1, 32'h00a00113, 1'b0, 1'b0, 32'h0);
    step();
    chk("late_rdy_valid", {31'b0, instr_valid}, 32'd1);
    chk("late_rdy_err",   {31'b0, fetch_err},   32'd0);
    chk("late_rdy_instr", instruction,          32'h00a00113);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    for (int c = 0; c < TIMEOUT - 1; c++) idle_step();
    chk("cnt_clear_err", {31'b0, fetch_err}, 32'd0);
    chk("cnt_clear_req", {31'b0, imem_req},  32'd1);
    chk("cnt_clear_addr", imem_addr,         32'h4);
    idle_step();
    chk("cnt_clear_tmo", {30'b0, err_code}, 32'd1);

    // Reset while waiting at 0x40.
    do_reset();
    drive(1'b0, 1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
    step();
    idle_step();
    idle_step();
    chk("midrst_pre_addr", imem_addr, 32'h40);
    chk("midrst_pre_ret",  retired,   32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("midrst_addr", imem_addr,          32'h0);
    chk("midrst_req",  {31'b0, imem_req},  32'd1);
    chk("midrst_err",  {31'b0, fetch_err}, 32'd0);
    chk("midrst_ret",  retired,            32'd0);

    // PC wraps from the top of the address space to zero.
    drive(1'b0, 1'b1, 32'h00000013, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hffff_fffc);
    step();
    chk("wrap_req_addr", imem_addr, 32'hffff_fffc);
    drive(1'b0, 1'b1, 32'h00000033, 1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_pc",     pc,          32'h0);
    chk("wrap_pc_cur", pc_cur,      32'hffff_fffc);
    chk("wrap_instr",  instruction, 32'h00000033);
    chk("wrap_ret",    retired,     32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
